// File: rtl/pci_target_mem.sv
// PCI memory-space target: claims its own address window and serves single and burst reads/writes
// from a local word array, with byte enables, initial wait states and disconnect at the window end.
module pci_target_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
    parameter int          DEPTH       = 8,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_n,
    input  logic        irdy_n,
    inout  wire  [31:0] ad,
    input  logic [3:0]  c_be,
    output wire         devsel_n,
    output wire         trdy_n,
    output wire         stop_n
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [29:0] BASE_W = BASE_ADDR[31:2];

    typedef enum logic [2:0] {S_IDLE, S_BUSY, S_WAIT, S_XFER, S_STOP, S_TURN} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          index_q, index_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   rd_q, rd_d;
    logic [DEPTH-1:0][31:0] mem_q, mem_d;

    logic [29:0] aw;
    logic        claim, last;

    assign aw    = ad[31:2];
    // MemRd (0110) and MemWr (0111) differ only in bit 0
    assign claim = (c_be[3:1] == 3'b011) && (aw >= BASE_W) && (aw <= BASE_W + 30'(DEPTH - 1));
    assign last  = (index_q == IW'(DEPTH - 1));

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        mem_d   = mem_q;
        case (state_q)
            S_IDLE: begin
                if (!frame_n) begin
                    if (claim) begin
                        rd_d    = !c_be[0];
                        index_d = ad[IW+1:2];
                        // a read needs one extra cycle for the AD turnaround
                        cnt_d   = 4'(WAIT_STATES) + {3'b000, !c_be[0]};
                        state_d = (WAIT_STATES == 0 && c_be[0]) ? S_XFER : S_WAIT;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: if (frame_n && irdy_n) state_d = S_IDLE;
            S_WAIT: begin
                if (frame_n && irdy_n) begin
                    state_d = S_TURN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (frame_n && irdy_n) begin
                    state_d = S_TURN;
                end else if (!irdy_n) begin
                    index_d = index_q + 1'b1;
                    if (!rd_q) begin
                        for (int k = 0; k < 4; k++)
                            if (!c_be[k]) mem_d[index_q][8*k +: 8] = ad[8*k +: 8];
                    end
                    if (frame_n)   state_d = S_TURN;
                    else if (last) state_d = S_STOP;
                end
            end
            S_STOP: if (frame_n) state_d = S_TURN;
            S_TURN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            index_q <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            mem_q   <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            mem_q   <= mem_d;
        end
    end

    // control lines are owned from claim until one cycle after release (TURN drives them high)
    logic ctl_oe;
    assign ctl_oe   = (state_q == S_WAIT) || (state_q == S_XFER) || (state_q == S_STOP) || (state_q == S_TURN);
    assign devsel_n = ctl_oe ? (state_q == S_TURN) : 1'bz;
    assign trdy_n   = ctl_oe ? (state_q != S_XFER) : 1'bz;
    assign stop_n   = ctl_oe ? !((state_q == S_STOP) || (state_q == S_XFER && last)) : 1'bz;
    assign ad       = (state_q == S_XFER && rd_q) ? mem_q[index_q] : 32'bz;
endmodule

// File: tb/tb_pci_target_mem.sv
// Bench for pci_target_mem: two targets (0x100 no waits, 0x400 two waits) on one pulled-up bus,
// directed cases plus random traffic checked against a word-array model of both windows.
module tb_pci_target_mem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_n = 1'b1;
    logic        irdy_n = 1'b1;
    logic [3:0]  c_be = 4'hF;
    logic [31:0] ad_drv = '0;
    logic        ad_oe = 1'b0;
    tri1  [31:0] ad;
    tri1         devsel_n, trdy_n, stop_n;

    assign ad = ad_oe ? ad_drv : 32'bz;
    always #5 clk = ~clk;

    pci_target_mem #(.BASE_ADDR(32'h100), .DEPTH(8), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .frame_n(frame_n), .irdy_n(irdy_n), .ad(ad),
        .c_be(c_be), .devsel_n(devsel_n), .trdy_n(trdy_n), .stop_n(stop_n));
    pci_target_mem #(.BASE_ADDR(32'h400), .DEPTH(8), .WAIT_STATES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .frame_n(frame_n), .irdy_n(irdy_n), .ad(ad),
        .c_be(c_be), .devsel_n(devsel_n), .trdy_n(trdy_n), .stop_n(stop_n));

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [2][8];
    logic [31:0] wdat [16];
    logic [3:0]  wbe  [16];
    logic [31:0] rdat [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int tgt(input logic [31:0] a);
        if (a >= 32'h100 && a < 32'h120) return 0;
        if (a >= 32'h400 && a < 32'h420) return 1;
        return -1;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 8; j++) mdl[i][j] = '0;
    endtask

    task automatic drive(input bit rd, input int n, input int nx, input int wt);
        irdy_n  = (wt > 0);
        frame_n = (wt == 0 && nx == n - 1);
        ad_oe   = !rd;
        ad_drv  = wdat[nx];
        c_be    = wbe[nx];
    endtask

    // one initiator transaction; starts and ends on a negedge with the bus idle
    task automatic txn(input logic [31:0] addr, input logic [3:0] cmd, input int n, input int iwait,
                       input int hold, input bit claimed,
                       output int nx, output int td, output int tt, output bit st);
        int t, w, cyc, wt, lim;
        bit rd;
        t = tgt(addr); w = int'(addr[4:2]); rd = (cmd == 4'h6);
        lim = claimed ? 40 : 6;
        nx = 0; td = -1; tt = -1; st = 1'b0; wt = iwait; cyc = 1;
        frame_n = 1'b0; ad_oe = 1'b1; ad_drv = addr; c_be = cmd;
        @(negedge clk);
        drive(rd, n, nx, wt);
        while (nx < n && !st && cyc < lim) begin
            #1;
            if (td < 0 && devsel_n === 1'b0) td = cyc;
            if (tt < 0 && trdy_n === 1'b0) tt = cyc;
            if (rd && devsel_n === 1'b0 && trdy_n === 1'b1) chk("rd_wait_ad_released", ad, '1);
            if (trdy_n === 1'b0 && claimed && t >= 0 && w + nx < 8) begin
                if (rd) begin
                    if (irdy_n) chk("rd_data_held", ad, mdl[t][w+nx]);
                    else        chk("rd_data", ad, mdl[t][w+nx]);
                end else if (!irdy_n) begin
                    for (int k = 0; k < 4; k++)
                        if (!c_be[k]) mdl[t][w+nx][8*k +: 8] = ad_drv[8*k +: 8];
                end
            end
            if (trdy_n === 1'b0 && !irdy_n) begin
                if (rd) rdat[nx] = ad;
                if (stop_n === 1'b0) st = 1'b1;
                nx++;
            end
            @(negedge clk); cyc++;
            if (wt > 0) wt--;
            if (nx < n && !st) drive(rd, n, nx, wt);
        end
        if (st && !frame_n) begin
            irdy_n = 1'b1; ad_oe = 1'b0;
            for (int h = 0; h <= hold; h++) begin
                #1; chk("stop_hold_ctl", {devsel_n, trdy_n, stop_n}, 3'b010);
                @(negedge clk);
            end
            frame_n = 1'b1;
            @(negedge clk);
        end
        frame_n = 1'b1; irdy_n = 1'b1; ad_oe = 1'b0; c_be = 4'hF;
        @(negedge clk); #1;
        chk("idle_ctl", {devsel_n, trdy_n, stop_n}, 3'b111);
        chk("idle_ad", ad, 32'hFFFF_FFFF);
    endtask

    task automatic run(input logic [31:0] addr, input logic [3:0] cmd, input int n, input int iwait,
                       input int hold);
        int t, w, en, nx, td, tt;
        bit st, claimed;
        t = tgt(addr); w = int'(addr[4:2]);
        claimed = (t >= 0) && (cmd == 4'h6 || cmd == 4'h7);
        txn(addr, cmd, n, iwait, hold, claimed, nx, td, tt, st);
        if (claimed) begin
            en = (n < 8 - w) ? n : 8 - w;
            chk("xfer_count", nx, en);
            chk("disconnect", st, (w + en == 8));
            chk("devsel_cycle", td, 1);
            chk("trdy_cycle", tt, (t == 1 ? 2 : 0) + (cmd == 4'h6 ? 1 : 0) + 1);
        end else begin
            chk("foreign_count", nx, 0);
            chk("foreign_devsel", td, -1);
        end
    endtask

    initial begin
        int ok;
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin wdat[i] = '0; wbe[i] = 4'h0; rdat[i] = '0; end
        clear_model();
        #2;
        chk("reset_ctl", {devsel_n, trdy_n, stop_n}, 3'b111);
        chk("reset_ad", ad, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(32'h100, 4'h6, 1, 0, 0);
        chk("single_rd_zero", rdat[0], 32'h0);

        wdat[0] = 32'hFFFF_FFFF; wbe[0] = 4'b1010;
        run(32'h108, 4'h7, 1, 0, 0);
        wbe[0] = 4'h0;
        run(32'h108, 4'h6, 1, 0, 0);
        chk("byte_enable_rd", rdat[0], 32'h00FF_00FF);

        for (int i = 0; i < 4; i++) begin wdat[i] = 32'h1111_1111 * (i + 1); wbe[i] = 4'h0; end
        run(32'h104, 4'h7, 4, 0, 0);
        run(32'h104, 4'h6, 4, 0, 0);
        for (int i = 0; i < 4; i++) chk("burst_readback", rdat[i], 32'h1111_1111 * (i + 1));

        wdat[0] = 32'hA5C3_0F96;
        run(32'h400, 4'h7, 1, 0, 0);
        run(32'h400, 4'h6, 1, 2, 0);
        chk("ws2_rd", rdat[0], 32'hA5C3_0F96);

        run(32'h200, 4'h6, 1, 0, 0);
        run(32'h100, 4'h2, 1, 0, 0);

        for (int i = 0; i < 4; i++) wdat[i] = 32'hC0DE_0000 + i;
        run(32'h118, 4'h7, 4, 0, 2);
        run(32'h118, 4'h6, 2, 0, 0);
        chk("edge_rd0", rdat[0], 32'hC0DE_0000);
        chk("edge_rd1", rdat[1], 32'hC0DE_0001);

        // master abort while the two-wait target is still in its wait states
        frame_n = 1'b0; ad_oe = 1'b1; ad_drv = 32'h404; c_be = 4'h6;
        @(negedge clk);
        frame_n = 1'b1; irdy_n = 1'b1; ad_oe = 1'b0; c_be = 4'hF;
        #1; chk("abort_claimed", devsel_n, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("abort_released", {devsel_n, trdy_n}, 2'b11);
        end

        for (int r = 0; r < 30; r++) begin
            int t, w, n, cmdsel;
            t = int'($urandom_range(0, 1)); w = int'($urandom_range(0, 7));
            n = int'($urandom_range(1, 5)); cmdsel = int'($urandom_range(0, 9));
            a = (t == 1 ? 32'h400 : 32'h100) + 32'(4 * w);
            for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wbe[i] = 4'($urandom); end
            if (cmdsel == 0)      run(32'h200 + 32'(4 * w), 4'h6, n, 0, 0);
            else if (cmdsel == 1) run(a, 4'h2, n, 0, 0);
            else if (cmdsel < 6)  run(a, 4'h7, n, int'($urandom_range(0, 2)), 0);
            else                  run(a, 4'h6, n, int'($urandom_range(0, 2)), 0);
        end

        // reset in the middle of a read burst
        frame_n = 1'b0; ad_oe = 1'b1; ad_drv = 32'h104; c_be = 4'h6;
        @(negedge clk);
        irdy_n = 1'b0; ad_oe = 1'b0; c_be = 4'h0;
        ok = 0;
        for (int i = 0; i < 10 && ok == 0; i++) begin
            @(negedge clk);
            if (trdy_n === 1'b0) ok = 1;
        end
        chk("midburst_trdy_seen", ok, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midburst_reset_ctl", {devsel_n, trdy_n, stop_n}, 3'b111);
        chk("midburst_reset_ad", ad, 32'hFFFF_FFFF);
        frame_n = 1'b1; irdy_n = 1'b1; c_be = 4'hF;
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) wbe[i] = 4'h0;
        run(32'h100, 4'h6, 8, 0, 0);
        chk("cleared_word3", rdat[3], 32'h0);
        run(32'h400, 4'h6, 1, 0, 0);
        chk("cleared_ws2", rdat[0], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
